// File: rtl/proj_multilane_pkg.sv
// Shared constants and types for the multi-lane sequence generator/checker.
// Holds the mode codes, the checker state encoding and the maximal-length LFSR tap table.
package proj_multilane_pkg;

    localparam int MODE_CNTR = 0;
    localparam int MODE_LFSR = 1;

    // Backpressure LFSR: seed base (xor'ed with the lane index) and x^16+x^15+x^13+x^4 taps
    localparam logic [15:0] STALL_SEED = 16'hACE1;
    localparam logic [15:0] STALL_TAPS = 16'hD008;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } chk_state_t;

    // Fibonacci tap mask; bit n-1 set means stage n feeds the xor
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            4:       lfsr_taps = 32'h0000_000C;
            5:       lfsr_taps = 32'h0000_0014;
            6:       lfsr_taps = 32'h0000_0030;
            7:       lfsr_taps = 32'h0000_0060;
            8:       lfsr_taps = 32'h0000_00B8;
            9:       lfsr_taps = 32'h0000_0110;
            10:      lfsr_taps = 32'h0000_0240;
            11:      lfsr_taps = 32'h0000_0500;
            12:      lfsr_taps = 32'h0000_0829;
            13:      lfsr_taps = 32'h0000_100D;
            14:      lfsr_taps = 32'h0000_2015;
            15:      lfsr_taps = 32'h0000_6000;
            16:      lfsr_taps = 32'h0000_D008;
            17:      lfsr_taps = 32'h0001_2000;
            18:      lfsr_taps = 32'h0002_0400;
            19:      lfsr_taps = 32'h0004_0023;
            20:      lfsr_taps = 32'h0009_0000;
            21:      lfsr_taps = 32'h0014_0000;
            22:      lfsr_taps = 32'h0030_0000;
            23:      lfsr_taps = 32'h0042_0000;
            24:      lfsr_taps = 32'h00E1_0000;
            25:      lfsr_taps = 32'h0120_0000;
            26:      lfsr_taps = 32'h0200_0023;
            27:      lfsr_taps = 32'h0400_0013;
            28:      lfsr_taps = 32'h0900_0000;
            29:      lfsr_taps = 32'h1400_0000;
            30:      lfsr_taps = 32'h2000_0029;
            31:      lfsr_taps = 32'h4800_0000;
            32:      lfsr_taps = 32'h8020_0003;
            default: lfsr_taps = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/proj_multilane_chk_lane.sv
// One lane: sequence generator on the outbound handshake plus a resynchronising checker on the return path.
// Optional random backpressure on chkrdy when PROJ_MULTILANE_STALL_EN is defined.
module proj_lane_chk
    import proj_multilane_pkg::*;
#(
    parameter int          W          = 16,
    parameter int          EW         = 8,
    parameter int          X          = 1,
    parameter int          MODE       = MODE_CNTR,
    parameter logic [W-1:0] START     = '0,
    parameter logic [15:0] STALL_INIT = STALL_SEED
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [W-1:0]  gendata,
    output logic          genvld,
    input  logic          genrdy,
    input  logic [W-1:0]  chkdata,
    input  logic          chkvld,
    output logic          chkrdy,
    output logic [EW-1:0] errcntr,
    output logic          locked,
    output logic          errnz
);

    localparam logic [31:0]   TAPS32  = lfsr_taps(W);
    localparam logic [W-1:0]  TAPS    = TAPS32[W-1:0];
    localparam logic [31:0]   X32     = X;
    localparam logic [W-1:0]  XINC    = X32[W-1:0];
    localparam logic [EW-1:0] ERR_MAX = '1;

    function automatic logic [W-1:0] nxt(input logic [W-1:0] v);
        if (MODE == MODE_LFSR)
            nxt = {v[W-2:0], ^(v & TAPS)};
        else
            nxt = v + XINC;
    endfunction

    logic [W-1:0]  gendata_reg;
    logic          genvld_reg;
    logic [W-1:0]  exp_reg;
    logic [EW-1:0] errcntr_reg;
    logic          errnz_reg;
    chk_state_t    state_reg, state_next;
    logic          beat_gen, beat_chk, compare, mismatch;

`ifdef PROJ_MULTILANE_STALL_EN
    logic [15:0] stall_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_reg <= STALL_INIT;
        else if (en)
            stall_reg <= {stall_reg[14:0], ^(stall_reg & STALL_TAPS)};
    end

    assign chkrdy = en & ~stall_reg[0];
`else
    assign chkrdy = en;
`endif

    assign beat_gen = genvld_reg & genrdy;
    assign beat_chk = chkvld & chkrdy;
    // Beats arriving while IDLE are consumed but never compared
    assign compare  = beat_chk & (state_reg != IDLE);
    assign mismatch = (chkdata != exp_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gendata_reg <= START;
            genvld_reg  <= 1'b0;
        end else begin
            genvld_reg <= en;
            if (clr)
                gendata_reg <= START;
            else if (beat_gen)
                gendata_reg <= nxt(gendata_reg);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:     if (en) state_next = RUN;
                RUN, ERR: if (compare) state_next = mismatch ? ERR : RUN;
                default:  state_next = IDLE;
            endcase
        end
    end

    // On a mismatch the expectation restarts from the received word so one fault is not reported forever
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_reg     <= START;
            errcntr_reg <= '0;
            errnz_reg   <= 1'b0;
        end else begin
            errnz_reg <= (errcntr_reg != '0);
            if (clr) begin
                exp_reg     <= START;
                errcntr_reg <= '0;
            end else if (compare) begin
                if (mismatch) begin
                    exp_reg <= nxt(chkdata);
                    if (errcntr_reg != ERR_MAX)
                        errcntr_reg <= errcntr_reg + 1'b1;
                end else begin
                    exp_reg <= nxt(exp_reg);
                end
            end
        end
    end

    assign gendata = gendata_reg;
    assign genvld  = genvld_reg;
    assign errcntr = errcntr_reg;
    assign locked  = (state_reg == RUN);
    assign errnz   = errnz_reg;

endmodule

// File: rtl/proj_multilane_chk.sv
// Multi-lane traffic generator/checker: L independent counter/LFSR lanes with per-lane error counts.
// Define PROJ_MULTILANE_STALL_EN to add pseudo-random backpressure on each lane's chkrdy.
module proj_multilane_chk
    import proj_multilane_pkg::*;
#(
    parameter int W    = 16,
    parameter int L    = 4,
    parameter int EW   = 8,
    parameter int X    = 1,
    parameter int MODE = MODE_CNTR,
    parameter int SEED = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    output logic [L*W-1:0]  gendata,
    output logic [L-1:0]    genvld,
    input  logic [L-1:0]    genrdy,
    input  logic [L*W-1:0]  chkdata,
    input  logic [L-1:0]    chkvld,
    output logic [L-1:0]    chkrdy,
    output logic [L*EW-1:0] errcntr,
    output logic [L-1:0]    locked,
    output logic            errany
);

    logic [L-1:0] errnz;

    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_lane
            localparam logic [W-1:0] START = (MODE == MODE_LFSR) ? W'(SEED + gi) : '0;

            proj_lane_chk #(
                .W          (W),
                .EW         (EW),
                .X          (X),
                .MODE       (MODE),
                .START      (START),
                .STALL_INIT (STALL_SEED ^ 16'(gi))
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .clr     (clr),
                .gendata (gendata[gi*W +: W]),
                .genvld  (genvld[gi]),
                .genrdy  (genrdy[gi]),
                .chkdata (chkdata[gi*W +: W]),
                .chkvld  (chkvld[gi]),
                .chkrdy  (chkrdy[gi]),
                .errcntr (errcntr[gi*EW +: EW]),
                .locked  (locked[gi]),
                .errnz   (errnz[gi])
            );
        end
    endgenerate

    // Each errnz is already a register, so errany trails errcntr by one edge
    assign errany = |errnz;

endmodule

// File: tb/tb_proj_multilane_chk.sv
// Directed bench for proj_multilane_chk: a 4x16-bit counter instance, a W=4/X=3/EW=4 instance and a W=4 LFSR instance.
module tb_proj_multilane_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Main instance: W=16, L=4, EW=8, X=1, counter mode
    logic        rst, en, clr, loop;
    logic [63:0] gendata, chkdata, chkdata_d;
    logic [3:0]  genvld, genrdy, chkvld, chkrdy, locked, genrdy_d, chkvld_d;
    logic [31:0] errcntr;
    logic        errany;

    assign genrdy  = loop ? chkrdy  : genrdy_d;
    assign chkvld  = loop ? genvld  : chkvld_d;
    assign chkdata = loop ? gendata : chkdata_d;

    proj_multilane_chk #(.W(16), .L(4), .EW(8), .X(1), .MODE(0), .SEED(1)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .gendata(gendata), .genvld(genvld), .genrdy(genrdy),
        .chkdata(chkdata), .chkvld(chkvld), .chkrdy(chkrdy),
        .errcntr(errcntr), .locked(locked), .errany(errany)
    );

    // Wrap/saturation instance: W=4, L=1, EW=4, X=3
    logic       en2, clr2, loop2, genvld2, genrdy2, chkvld2, chkrdy2, locked2, errany2, chkvld2_d;
    logic [3:0] gendata2, chkdata2, chkdata2_d, errcntr2;

    assign genrdy2  = loop2 ? chkrdy2  : 1'b0;
    assign chkvld2  = loop2 ? genvld2  : chkvld2_d;
    assign chkdata2 = loop2 ? gendata2 : chkdata2_d;

    proj_multilane_chk #(.W(4), .L(1), .EW(4), .X(3), .MODE(0), .SEED(1)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .clr(clr2),
        .gendata(gendata2), .genvld(genvld2), .genrdy(genrdy2),
        .chkdata(chkdata2), .chkvld(chkvld2), .chkrdy(chkrdy2),
        .errcntr(errcntr2), .locked(locked2), .errany(errany2)
    );

    // LFSR instance: W=4, L=2, permanently looped back
    logic       en3, clr3, errany3;
    logic [7:0] gendata3, errcntr3;
    logic [1:0] genvld3, chkrdy3, locked3;

    proj_multilane_chk #(.W(4), .L(2), .EW(4), .X(1), .MODE(1), .SEED(1)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .clr(clr3),
        .gendata(gendata3), .genvld(genvld3), .genrdy(chkrdy3),
        .chkdata(gendata3), .chkvld(genvld3), .chkrdy(chkrdy3),
        .errcntr(errcntr3), .locked(locked3), .errany(errany3)
    );

    logic [3:0] wrap_tab [20] = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2, 4'd5, 4'd8, 4'd11,
                                  4'd14, 4'd1, 4'd4, 4'd7, 4'd10, 4'd13, 4'd0, 4'd3, 4'd6, 4'd9};
    logic [3:0] lfsr_tab0 [7] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13};
    logic [3:0] lfsr_tab1 [7] = '{4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returned words for the drop/corrupt scenario: lane 1 has 5 replaced by 7, lane 2 skips 5
    function automatic logic [15:0] seqv(input int l, input int k);
        int v;
        v = k;
        if (l == 1 && k == 5) v = 7;
        if (l == 2 && k >= 5) v = k + 1;
        seqv = 16'(v);
    endfunction

    task automatic test_reset();
        loop = 0; loop2 = 0; en = 0; en2 = 0; en3 = 0; clr = 0; clr2 = 0; clr3 = 0;
        genrdy_d = '0; chkvld_d = '0; chkdata_d = '0; chkvld2_d = 0; chkdata2_d = '0;
        rst = 0;
        repeat (3) tick();
        n_cmp++; if (gendata !== 64'h0) begin n_bad++; $display("FAIL reset_gendata: got %h want 0", gendata); end
        n_cmp++; if (genvld !== 4'h0) begin n_bad++; $display("FAIL reset_genvld: got %h want 0", genvld); end
        n_cmp++; if (chkrdy !== 4'h0) begin n_bad++; $display("FAIL reset_chkrdy: got %h want 0", chkrdy); end
        n_cmp++; if (errcntr !== 32'h0) begin n_bad++; $display("FAIL reset_errcntr: got %h want 0", errcntr); end
        n_cmp++; if (locked !== 4'h0 || errany !== 1'b0) begin n_bad++; $display("FAIL reset_locked_errany: got %h/%b want 0/0", locked, errany); end
        n_cmp++; if (gendata3 !== 8'h21) begin n_bad++; $display("FAIL reset_lfsr_start: got %h want 21", gendata3); end
        rst = 1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_loopback();
        int beats = 0;
        int cyc = 0;
        bit saw_rdy = 0;
        bit saw_stall = 0;
        loop = 1; en = 1;
        while (beats < 1000 && cyc < 5000) begin
            tick(); cyc++;
            if (chkrdy[0]) saw_rdy = 1; else saw_stall = 1;
            if (genvld[0] && genrdy[0]) begin
                n_cmp++;
                if (gendata[15:0] !== 16'(beats)) begin n_bad++; $display("FAIL loop_data beat %0d: got %0d want %0d", beats, gendata[15:0], beats); end
                beats++;
            end
        end
        n_cmp++; if (beats != 1000) begin n_bad++; $display("FAIL loop_budget: got %0d beats want 1000", beats); end
        en = 0;
        tick(); tick();
        n_cmp++; if (errcntr !== 32'h0) begin n_bad++; $display("FAIL loop_errcntr: got %h want 0", errcntr); end
        n_cmp++; if (locked !== 4'hF) begin n_bad++; $display("FAIL loop_locked: got %h want F", locked); end
        n_cmp++; if (errany !== 1'b0) begin n_bad++; $display("FAIL loop_errany: got %b want 0", errany); end
        n_cmp++; if (gendata[15:0] !== 16'd999) begin n_bad++; $display("FAIL loop_last: got %0d want 999", gendata[15:0]); end
`ifdef PROJ_MULTILANE_STALL_EN
        n_cmp++; if (!(saw_rdy && saw_stall)) begin n_bad++; $display("FAIL stall_toggle: got rdy=%b stall=%b want 1/1", saw_rdy, saw_stall); end
`else
        n_cmp++; if (saw_stall) begin n_bad++; $display("FAIL no_stall: got stall=%b want 0", saw_stall); end
`endif
        loop = 0;
        $display("test_loopback done: %0d beats in %0d cycles", beats, cyc);
    endtask

    task automatic test_lfsr();
        int i0 = 0;
        int i1 = 0;
        int cyc = 0;
        en3 = 1;
        while ((i0 < 7 || i1 < 7) && cyc < 300) begin
            tick(); cyc++;
            if (genvld3[0] && chkrdy3[0] && i0 < 7) begin
                n_cmp++;
                if (gendata3[3:0] !== lfsr_tab0[i0]) begin n_bad++; $display("FAIL lfsr_lane0 step %0d: got %0d want %0d", i0, gendata3[3:0], lfsr_tab0[i0]); end
                i0++;
            end
            if (genvld3[1] && chkrdy3[1] && i1 < 7) begin
                n_cmp++;
                if (gendata3[7:4] !== lfsr_tab1[i1]) begin n_bad++; $display("FAIL lfsr_lane1 step %0d: got %0d want %0d", i1, gendata3[7:4], lfsr_tab1[i1]); end
                i1++;
            end
        end
        n_cmp++; if (i0 < 7 || i1 < 7) begin n_bad++; $display("FAIL lfsr_budget: got %0d/%0d beats want 7/7", i0, i1); end
        en3 = 0;
        tick(); tick();
        n_cmp++; if (errcntr3 !== 8'h0 || locked3 !== 2'b11) begin n_bad++; $display("FAIL lfsr_status: got err=%h locked=%b want 00/11", errcntr3, locked3); end
        $display("test_lfsr done");
    endtask

    task automatic test_wrap();
        int beats = 0;
        int cyc = 0;
        loop2 = 1; en2 = 1;
        while (beats < 20 && cyc < 500) begin
            tick(); cyc++;
            if (genvld2 && genrdy2) begin
                n_cmp++;
                if (gendata2 !== wrap_tab[beats]) begin n_bad++; $display("FAIL wrap_data beat %0d: got %0d want %0d", beats, gendata2, wrap_tab[beats]); end
                beats++;
            end
        end
        n_cmp++; if (beats != 20) begin n_bad++; $display("FAIL wrap_budget: got %0d beats want 20", beats); end
        en2 = 0;
        tick(); tick();
        n_cmp++; if (errcntr2 !== 4'h0 || locked2 !== 1'b1) begin n_bad++; $display("FAIL wrap_status: got err=%0d locked=%b want 0/1", errcntr2, locked2); end
        loop2 = 0;
        $display("test_wrap done");
    endtask

    task automatic test_drop_corrupt();
        int idx [4] = '{0, 0, 0, 0};
        int cyc = 0;
        logic [3:0] acc;
        clr = 1; tick(); clr = 0;
        en = 1; genrdy_d = '0; chkvld_d = '0;
        tick();
        while ((idx[0] < 12 || idx[1] < 12 || idx[2] < 12 || idx[3] < 12) && cyc < 400) begin
            for (int l = 0; l < 4; l++) begin
                chkdata_d[l*16 +: 16] = seqv(l, idx[l]);
                chkvld_d[l] = (idx[l] < 12);
            end
            #1;
            acc = chkrdy & chkvld_d;
            tick(); cyc++;
            for (int l = 0; l < 4; l++) if (acc[l]) idx[l]++;
            if (acc[2] && idx[2] == 6) begin
                n_cmp++; if (locked[2] !== 1'b0) begin n_bad++; $display("FAIL drop_unlock: got %b want 0", locked[2]); end
            end
            if (acc[2] && idx[2] == 7) begin
                n_cmp++; if (locked[2] !== 1'b1) begin n_bad++; $display("FAIL drop_relock: got %b want 1", locked[2]); end
            end
        end
        n_cmp++; if (cyc >= 400) begin n_bad++; $display("FAIL drop_budget: got %0d cycles want <400", cyc); end
        chkvld_d = '0;
        tick(); tick();
        n_cmp++; if (errcntr !== 32'h00_01_02_00) begin n_bad++; $display("FAIL drop_corrupt_errcntr: got %h want 00010200", errcntr); end
        n_cmp++; if (locked !== 4'hF) begin n_bad++; $display("FAIL drop_corrupt_locked: got %h want F", locked); end
        n_cmp++; if (errany !== 1'b1) begin n_bad++; $display("FAIL drop_corrupt_errany: got %b want 1", errany); end
        $display("test_drop_corrupt done");
    endtask

    task automatic test_clr_beat();
        genrdy_d = 4'hF; chkvld_d = 4'hF; chkdata_d = {4{16'hBEEF}}; clr = 1;
        tick();
        clr = 0; en = 0; genrdy_d = '0; chkvld_d = '0;
        n_cmp++; if (errcntr !== 32'h0) begin n_bad++; $display("FAIL clr_errcntr: got %h want 0", errcntr); end
        n_cmp++; if (gendata !== 64'h0) begin n_bad++; $display("FAIL clr_gendata: got %h want 0", gendata); end
        n_cmp++; if (locked !== 4'h0) begin n_bad++; $display("FAIL clr_locked: got %h want 0", locked); end
        n_cmp++; if (errany !== 1'b1) begin n_bad++; $display("FAIL clr_errany_lag: got %b want 1", errany); end
        tick();
        n_cmp++; if (errany !== 1'b0) begin n_bad++; $display("FAIL clr_errany: got %b want 0", errany); end
        $display("test_clr_beat done");
    endtask

    task automatic test_saturate();
        int acc = 0;
        int cyc = 0;
        logic a;
        en2 = 1; chkvld2_d = 1; chkdata2_d = 4'd0;
        while (acc < 40 && cyc < 600) begin
            #1;
            a = chkrdy2;
            tick(); cyc++;
            if (a) begin
                acc++;
                if (acc == 5) begin
                    n_cmp++; if (errcntr2 !== 4'd5) begin n_bad++; $display("FAIL sat_partial: got %0d want 5", errcntr2); end
                end
            end
        end
        n_cmp++; if (acc != 40) begin n_bad++; $display("FAIL sat_budget: got %0d beats want 40", acc); end
        chkvld2_d = 0;
        tick();
        n_cmp++; if (errcntr2 !== 4'd15) begin n_bad++; $display("FAIL sat_errcntr: got %0d want 15", errcntr2); end
        n_cmp++; if (errany2 !== 1'b1 || locked2 !== 1'b0) begin n_bad++; $display("FAIL sat_flags: got errany=%b locked=%b want 1/0", errany2, locked2); end
        $display("test_saturate done");
    endtask

    task automatic test_reset_midrun();
        loop = 1; en = 1; en3 = 1;
        repeat (10) tick();
        #2;
        rst = 0; en = 0; en2 = 0; en3 = 0; loop = 0;
        #1;
        n_cmp++; if (gendata !== 64'h0 || genvld !== 4'h0) begin n_bad++; $display("FAIL midrst_gen: got %h/%h want 0/0", gendata, genvld); end
        n_cmp++; if (locked !== 4'h0 || chkrdy !== 4'h0) begin n_bad++; $display("FAIL midrst_chk: got locked=%h chkrdy=%h want 0/0", locked, chkrdy); end
        n_cmp++; if (errcntr2 !== 4'h0 || errany2 !== 1'b0) begin n_bad++; $display("FAIL midrst_err2: got %0d/%b want 0/0", errcntr2, errany2); end
        n_cmp++; if (gendata3 !== 8'h21 || genvld3 !== 2'b00) begin n_bad++; $display("FAIL midrst_lfsr: got %h/%b want 21/00", gendata3, genvld3); end
        repeat (2) tick();
        rst = 1;
        tick();
        n_cmp++; if (locked !== 4'h0 || errcntr !== 32'h0 || errany !== 1'b0) begin n_bad++; $display("FAIL postrst: got %h/%h/%b want 0/0/0", locked, errcntr, errany); end
        $display("test_reset_midrun done");
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_lfsr();
        test_wrap();
        test_drop_corrupt();
        test_clr_beat();
        test_saturate();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
